multi_input_conditioner: RTL and testbench
==========================================

// Module: multi_input_conditioner
// PURPOSE
//  N-channel input conditioner for raw pins, switches and buttons.
//  Each channel synchronises an asynchronous input, debounces it and gives
//  single-cycle rising/falling edge strobes.
//  Sits between top-level pins and control logic; replaces per-pin single-channel
//  conditioner instances with one parametrised block.
// PARAMETERS
//  CHANNELS     4  number of independent input channels (>=1)
//  SYNC_STAGES  2  synchroniser flop depth per channel (>=2)
//  WAIT_TIME    3  debounce count; a synced input must differ from conditioned for
//                  WAIT_TIME+1 consecutive clocks to be accepted (>=1)
//  Counter width is derived internally as $clog2(WAIT_TIME+1); no separate width parameter.
// PORTS
//  clk           in   1         system clock, 50 MHz nominal
//  reset         in   1         asynchronous, active-high reset
//  noisysignal   in   CHANNELS  raw asynchronous inputs, bit i = channel i
//  conditioned   out  CHANNELS  synchronised, debounced level per channel
//  positiveedge  out  CHANNELS  1-cycle strobe when conditioned[i] goes 0->1
//  negativeedge  out  CHANNELS  1-cycle strobe when conditioned[i] goes 1->0
//  flag_clear    in   CHANNELS  (COND_STICKY_FLAGS_EN only) clear sticky flags of channel i
//  pos_flag      out  CHANNELS  (COND_STICKY_FLAGS_EN only) sticky rising-edge flag
//  neg_flag      out  CHANNELS  (COND_STICKY_FLAGS_EN only) sticky falling-edge flag
// BEHAVIOUR
//  - Channels are fully independent. All state is per channel; there is no cross-channel coupling.
//  - Reset, asynchronous: sync flops, counter, conditioned, positiveedge, negativeedge
//    (and flags) clear to 0 immediately, without a clock edge.
//  - Synchroniser: SYNC_STAGES-flop shift chain clocked on posedge clk; sync_out = last stage.
//  - Debounce, each posedge clk:
//      sync_out == conditioned            -> counter <= 0
//      mismatch && counter != WAIT_TIME   -> counter <= counter + 1
//      mismatch && counter == WAIT_TIME   -> conditioned <= sync_out, counter <= 0
//  - Edge strobes are registered:
//      positiveedge[i] <= accept && sync_out==1
//      negativeedge[i] <= accept && sync_out==0
//    Each strobe is high for exactly one cycle, coincident with the first cycle of the new conditioned value.
//  - Latency: input stable from clock edge k -> conditioned/strobe update at edge
//    k+SYNC_STAGES+WAIT_TIME (defaults: 5 edges after the first capturing edge, 6 total).
//  - Glitch rejection: a mismatch lasting <= WAIT_TIME synced cycles returns the counter
//    to 0; conditioned and strobes are unchanged. Any return to match restarts the count.
//  - After an accept, the counter restarts from 0. Opposing transitions therefore cannot
//    both strobe within WAIT_TIME+1 cycles.
//  - Reset is 0: a channel held high through reset release produces one positiveedge
//    after the full latency. This is required behaviour and must not be masked.
//  - Reset asserted mid-count discards the count. After release, debouncing starts fresh from sync flops = 0.
//  - positiveedge and negativeedge are never both high on the same channel in the same cycle.
// CONFIGURATION
//  COND_STICKY_FLAGS_EN defined:
//   - Ports flag_clear, pos_flag and neg_flag exist.
//   - pos_flag[i] sets on positiveedge[i]; neg_flag[i] sets on negativeedge[i].
//   - Each flag holds until flag_clear[i] is sampled high on posedge clk.
//   - Set wins over clear in the same cycle.
//   - Flags reset to 0.
//  COND_STICKY_FLAGS_EN undefined: those ports and their logic are absent. Core behaviour is identical.
// TESTING (defaults, clk period 20 ns)
//  1. reset=1, noisysignal=4'hF: all outputs 0. Release reset -> conditioned=4'hF at the 6th
//     posedge, positiveedge=4'hF for exactly 1 cycle, then 0.
//  2. Channel 0 pulsed high for 3 clocks -> no change on any output.
//     Channel 0 pulsed high for 4 clocks -> conditioned[0] rises and positiveedge[0] pulses once,
//     then after the fall negativeedge[0] pulses once.
//  3. Channel 0 rises and channel 1 falls on the same edge (others static) ->
//     positiveedge=4'b0001 and negativeedge=4'b0010 in the same cycle.
//     Channels 2 and 3 stay unchanged.
//  4. Channel 3 rises; assert reset at 3 clocks + 5 ns -> all outputs 0 within the same
//     delta, no strobe. Release with the input still high -> strobe at the 6th posedge after release.
//  5. Bounce: channel 2 toggles every 2 clocks for 40 clocks, then holds 1 ->
//     exactly one positiveedge[2], 6 edges after the final hold.
//  6. COND_STICKY_FLAGS_EN: after test 1, pos_flag=4'hF persists until flag_clear=4'h1 -> 4'hE.
//     flag_clear[1] high in the same cycle as a new positiveedge[1] -> pos_flag[1] stays 1.

Source files
------------

// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner: per-channel synchroniser, debouncer and registered edge strobes.
// Define COND_STICKY_FLAGS_EN to add sticky edge flags with a per-channel clear.
`timescale 1ns/1ps
module multi_input_conditioner #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_TIME   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge
`ifdef COND_STICKY_FLAGS_EN
    ,
    input  logic [CHANNELS-1:0] flag_clear,
    output logic [CHANNELS-1:0] pos_flag,
    output logic [CHANNELS-1:0] neg_flag
`endif
);

    localparam int               CNT_W   = $clog2(WAIT_TIME + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIME);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   cond_q;
        logic                   pe_q;
        logic                   ne_q;
        logic                   sync_out;
        logic                   mismatch;
        logic                   accept;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], noisysignal[i]};
            end
        end

        assign sync_out = sync_q[SYNC_STAGES-1];
        assign mismatch = (sync_out != cond_q);
        // The new level is taken once the mismatch has been seen WAIT_TIME+1 times in a row.
        assign accept   = mismatch && (cnt_q == CNT_MAX);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                cond_q <= 1'b0;
                pe_q   <= 1'b0;
                ne_q   <= 1'b0;
            end else begin
                pe_q <= accept && sync_out;
                ne_q <= accept && !sync_out;
                if (!mismatch || accept) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (accept) begin
                    cond_q <= sync_out;
                end
            end
        end

        assign conditioned[i]  = cond_q;
        assign positiveedge[i] = pe_q;
        assign negativeedge[i] = ne_q;

`ifdef COND_STICKY_FLAGS_EN
        logic pf_q;
        logic nf_q;

        // A strobe arriving in the same cycle as a clear keeps the flag set.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pf_q <= 1'b0;
                nf_q <= 1'b0;
            end else begin
                if (pe_q) begin
                    pf_q <= 1'b1;
                end else if (flag_clear[i]) begin
                    pf_q <= 1'b0;
                end
                if (ne_q) begin
                    nf_q <= 1'b1;
                end else if (flag_clear[i]) begin
                    nf_q <= 1'b0;
                end
            end
        end

        assign pos_flag[i] = pf_q;
        assign neg_flag[i] = nf_q;
`endif
    end

endmodule

// File: tb/tb_multi_input_conditioner.sv
// tb_multi_input_conditioner: directed and randomized checks against a sample-window model.
// Flag checks are compiled in when COND_STICKY_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_multi_input_conditioner;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int WT  = 3;
    // negedges from an input change (made at a negedge) to the visible strobe
    localparam int LAT = SS + WT + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] noisysignal;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] positiveedge;
    logic [CH-1:0] negativeedge;
`ifdef COND_STICKY_FLAGS_EN
    logic [CH-1:0] flag_clear;
    logic [CH-1:0] pos_flag;
    logic [CH-1:0] neg_flag;
    logic [CH-1:0] m_pf;
    logic [CH-1:0] m_nf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: a level is accepted when the last WT+1 synced samples all disagree with it
    logic [CH-1:0] m_cond;
    logic [CH-1:0] m_pe;
    logic [CH-1:0] m_ne;
    logic [CH-1:0] m_s;
    logic [CH-1:0] pipe_q[$];
    logic [CH-1:0] win_q[$];
    bit            all_diff;

    always #10 clk = ~clk;

    multi_input_conditioner #(
        .CHANNELS   (CH),
        .SYNC_STAGES(SS),
        .WAIT_TIME  (WT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .noisysignal (noisysignal),
        .conditioned (conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge)
`ifdef COND_STICKY_FLAGS_EN
        ,
        .flag_clear  (flag_clear),
        .pos_flag    (pos_flag),
        .neg_flag    (neg_flag)
`endif
    );

    task automatic model_reset();
        m_cond = '0;
        m_pe   = '0;
        m_ne   = '0;
`ifdef COND_STICKY_FLAGS_EN
        m_pf   = '0;
        m_nf   = '0;
`endif
        pipe_q.delete();
        win_q.delete();
        for (int k = 0; k < SS; k++) pipe_q.push_back('0);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
`ifdef COND_STICKY_FLAGS_EN
            m_pf = m_pe | (m_pf & ~flag_clear);
            m_nf = m_ne | (m_nf & ~flag_clear);
`endif
            m_s = pipe_q.pop_front();
            pipe_q.push_back(noisysignal);
            win_q.push_back(m_s);
            if (win_q.size() > WT + 1) void'(win_q.pop_front());
            m_pe = '0;
            m_ne = '0;
            if (win_q.size() == WT + 1) begin
                for (int c = 0; c < CH; c++) begin
                    all_diff = 1'b1;
                    foreach (win_q[k]) if (win_q[k][c] == m_cond[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_cond[c] = m_s[c];
                        m_pe[c]   = m_s[c];
                        m_ne[c]   = ~m_s[c];
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [CH-1:0] exp_c, exp_p;
        reset       = 1'b1;
        noisysignal = '1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({conditioned, positiveedge, negativeedge} !== '0)
            $display("FAIL reset_hold: got %h required 000", {conditioned, positiveedge, negativeedge});
        else n_pass++;
`ifdef COND_STICKY_FLAGS_EN
        n_checks++;
        if ({pos_flag, neg_flag} !== '0)
            $display("FAIL reset_flags: got %h required 00", {pos_flag, neg_flag});
        else n_pass++;
`endif
        reset = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            exp_c = (k >= LAT) ? {CH{1'b1}} : '0;
            exp_p = (k == LAT) ? {CH{1'b1}} : '0;
            n_checks++;
            if (conditioned !== exp_c || positiveedge !== exp_p || negativeedge !== '0)
                $display("FAIL release_edge%0d: got c=%h p=%h n=%h required c=%h p=%h n=0",
                         k, conditioned, positiveedge, negativeedge, exp_c, exp_p);
            else n_pass++;
        end
    endtask

`ifdef COND_STICKY_FLAGS_EN
    task automatic test_sticky_flags();
        repeat (3) @(negedge clk);
        n_checks++;
        if (pos_flag !== 4'hF || neg_flag !== 4'h0)
            $display("FAIL flag_persist: got p=%h n=%h required p=f n=0", pos_flag, neg_flag);
        else n_pass++;
        flag_clear = 4'h1;
        @(negedge clk);
        flag_clear = '0;
        @(negedge clk);
        n_checks++;
        if (pos_flag !== 4'hE)
            $display("FAIL flag_clear0: got %h required e", pos_flag);
        else n_pass++;
        noisysignal[1] = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        n_checks++;
        if (neg_flag !== 4'h2 || pos_flag !== 4'hE)
            $display("FAIL flag_negset: got p=%h n=%h required p=e n=2", pos_flag, neg_flag);
        else n_pass++;
        noisysignal[1] = 1'b1;
        repeat (LAT) @(negedge clk);
        n_checks++;
        if (positiveedge !== 4'h2)
            $display("FAIL flag_strobe1: got %h required 2", positiveedge);
        else n_pass++;
        flag_clear = 4'h2;
        @(negedge clk);
        flag_clear = '0;
        n_checks++;
        if (pos_flag !== 4'hE || neg_flag !== 4'h0)
            $display("FAIL flag_setwins: got p=%h n=%h required p=e n=0", pos_flag, neg_flag);
        else n_pass++;
        n_checks++;
        if ({pos_flag, neg_flag} !== {m_pf, m_nf})
            $display("FAIL flag_model: got %h required %h", {pos_flag, neg_flag}, {m_pf, m_nf});
        else n_pass++;
    endtask
`endif

    task automatic test_glitch();
        int pe_cnt = 0;
        int ne_cnt = 0;
        noisysignal = '0;
        repeat (LAT + 2) @(negedge clk);
        noisysignal[0] = 1'b1;
        repeat (WT) @(negedge clk);
        noisysignal[0] = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({conditioned, positiveedge, negativeedge} !== '0)
                $display("FAIL glitch_short%0d: got %h required 000", k,
                         {conditioned, positiveedge, negativeedge});
            else n_pass++;
        end
        noisysignal[0] = 1'b1;
        for (int k = 0; k < 3 * LAT; k++) begin
            if (k == WT + 1) noisysignal[0] = 1'b0;
            @(negedge clk);
            pe_cnt += int'(positiveedge[0]);
            ne_cnt += int'(negativeedge[0]);
            n_checks++;
            if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pe, m_ne})
                $display("FAIL glitch_long%0d: got %h required %h", k,
                         {conditioned, positiveedge, negativeedge}, {m_cond, m_pe, m_ne});
            else n_pass++;
        end
        n_checks++;
        if (pe_cnt != 1 || ne_cnt != 1)
            $display("FAIL glitch_long_count: got pe=%0d ne=%0d required 1 1", pe_cnt, ne_cnt);
        else n_pass++;
    endtask

    task automatic test_opposing();
        logic [CH-1:0] exp_c, exp_p, exp_n;
        noisysignal = 4'b1010;
        repeat (LAT + 2) @(negedge clk);
        noisysignal = 4'b1001;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            exp_c = (k >= LAT) ? 4'b1001 : 4'b1010;
            exp_p = (k == LAT) ? 4'b0001 : 4'b0000;
            exp_n = (k == LAT) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (conditioned !== exp_c || positiveedge !== exp_p || negativeedge !== exp_n)
                $display("FAIL opposing%0d: got c=%h p=%h n=%h required c=%h p=%h n=%h",
                         k, conditioned, positiveedge, negativeedge, exp_c, exp_p, exp_n);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midcount();
        logic [CH-1:0] exp_c, exp_p;
        noisysignal = 4'b0111;
        repeat (LAT + 2) @(negedge clk);
        noisysignal[3] = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({conditioned, positiveedge, negativeedge} !== '0)
            $display("FAIL midcount_async: got %h required 000", {conditioned, positiveedge, negativeedge});
        else n_pass++;
`ifdef COND_STICKY_FLAGS_EN
        n_checks++;
        if ({pos_flag, neg_flag} !== '0)
            $display("FAIL midcount_flags: got %h required 00", {pos_flag, neg_flag});
        else n_pass++;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            exp_c = (k >= LAT) ? 4'hF : 4'h0;
            exp_p = (k == LAT) ? 4'hF : 4'h0;
            n_checks++;
            if (conditioned !== exp_c || positiveedge !== exp_p || negativeedge !== '0)
                $display("FAIL midcount_release%0d: got c=%h p=%h n=%h required c=%h p=%h n=0",
                         k, conditioned, positiveedge, negativeedge, exp_c, exp_p);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int bounce_strobes = 0;
        int hold_pe = 0;
        noisysignal[2] = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        for (int t = 0; t < 20; t++) begin
            noisysignal[2] = ~noisysignal[2];
            repeat (2) begin
                @(negedge clk);
                bounce_strobes += int'(positiveedge[2]) + int'(negativeedge[2]);
                n_checks++;
                if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pe, m_ne})
                    $display("FAIL bounce_toggle%0d: got %h required %h", t,
                             {conditioned, positiveedge, negativeedge}, {m_cond, m_pe, m_ne});
                else n_pass++;
            end
        end
        n_checks++;
        if (bounce_strobes != 0 || conditioned !== 4'b1011)
            $display("FAIL bounce_reject: got strobes=%0d c=%h required 0 b", bounce_strobes, conditioned);
        else n_pass++;
        noisysignal[2] = 1'b1;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            hold_pe += int'(positiveedge[2]);
            n_checks++;
            if (positiveedge !== ((k == LAT) ? 4'b0100 : 4'b0000))
                $display("FAIL bounce_hold%0d: got p=%h required %h", k, positiveedge,
                         (k == LAT) ? 4'b0100 : 4'b0000);
            else n_pass++;
        end
        n_checks++;
        if (hold_pe != 1)
            $display("FAIL bounce_count: got %0d required 1", hold_pe);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 4) == 0) noisysignal[c] = ~noisysignal[c];
`ifdef COND_STICKY_FLAGS_EN
            flag_clear = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
`endif
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            n_checks++;
            if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pe, m_ne})
                $display("FAIL random%0d: got %h required %h", cyc,
                         {conditioned, positiveedge, negativeedge}, {m_cond, m_pe, m_ne});
            else n_pass++;
            n_checks++;
            if ((positiveedge & negativeedge) !== '0)
                $display("FAIL random_both%0d: got %h required 0", cyc, positiveedge & negativeedge);
            else n_pass++;
`ifdef COND_STICKY_FLAGS_EN
            n_checks++;
            if ({pos_flag, neg_flag} !== {m_pf, m_nf})
                $display("FAIL random_flags%0d: got %h required %h", cyc, {pos_flag, neg_flag}, {m_pf, m_nf});
            else n_pass++;
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        noisysignal = '1;
`ifdef COND_STICKY_FLAGS_EN
        flag_clear  = '0;
`endif
        test_reset();
`ifdef COND_STICKY_FLAGS_EN
        test_sticky_flags();
`endif
        test_glitch();
        test_opposing();
        test_reset_midcount();
        test_bounce();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
